// File: rtl/aes_pkg.sv
// Shared AES types: byte-matrix block, round count, add-round-key FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aes_pkg;

    // 16-byte AES state or round key, indexed [row][col][bit].
    typedef logic [3:0][3:0][7:0] aes_block_t;

    // AES-128 uses rounds 0..10; round 0 is the initial key whitening.
    localparam int NUM_ROUNDS_AES128 = 10;

    typedef enum logic [2:0] {
        IDLE,
        REQ_KEY,
        XOR,
        OUT,
        ERR
    } ark_state_t;

endpackage

// File: rtl/aes_add_round_key_if.sv
// Bus bundle for the add-round-key stage: state in, key request/response, state out.
// Latency: n/a (wires only).
// Backpressure: valid/rdy on state_in and state_out, key_req/key_rdy towards the key expander.
interface aes_add_round_key_if;
    import aes_pkg::*;

    aes_block_t state_in;
    logic       state_in_valid;
    logic [3:0] round_no;
    logic       state_in_rdy;

    logic       key_req;
    logic [3:0] key_sel;
    logic       key_rdy;
    aes_block_t round_key;

    aes_block_t state_out;
    logic       state_out_valid;
    logic       state_out_rdy;
    logic       err;

    // Block side.
    modport slave (
        input  state_in, state_in_valid, round_no, key_rdy, round_key, state_out_rdy,
        output state_in_rdy, key_req, key_sel, state_out, state_out_valid, err
    );

    // Upstream / key expander / downstream side.
    modport master (
        output state_in, state_in_valid, round_no, key_rdy, round_key, state_out_rdy,
        input  state_in_rdy, key_req, key_sel, state_out, state_out_valid, err
    );

endinterface

// File: rtl/aes_add_round_key.sv
// AES AddRoundKey stage: fetch round key for the accepted state, XOR all 16 bytes, hand result on.
// Latency: accept at cycle 0, key_req from cycle 1, key_rdy seen at cycle k -> state_out_valid at k+2.
// Backpressure: accepts one state at a time; result held stable until state_out_rdy; key wait bounded by KEY_TIMEOUT.
module aes_add_round_key
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS  = NUM_ROUNDS_AES128,
    parameter int KEY_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                resetn,
    aes_add_round_key_if.slave  bus
);

    localparam int               CNT_W    = (KEY_TIMEOUT > 1) ? $clog2(KEY_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(KEY_TIMEOUT - 1);

    ark_state_t       state_q;
    ark_state_t       state_d;
    aes_block_t       blk_q;
    aes_block_t       key_q;
    aes_block_t       out_q;
    logic [3:0]       round_q;
    logic [CNT_W-1:0] cnt_q;
    logic             round_bad;

    // Rounds above the configured maximum have no key and are rejected up front.
    assign round_bad = (32'(bus.round_no) > NUM_ROUNDS);

    // FSM state register; reset drops any operation in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; key_rdy is checked before the timeout so a last-cycle key still wins.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.state_in_valid) begin
                    state_d = round_bad ? ERR : REQ_KEY;
                end
            end
            REQ_KEY: begin
                if (bus.key_rdy) begin
                    state_d = XOR;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ERR;
                end
            end
            XOR:     state_d = OUT;
            OUT: begin
                if (bus.state_out_rdy) begin
                    state_d = IDLE;
                end
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath capture and key-wait counter; the counter restarts from 0 on each entry to REQ_KEY.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blk_q   <= '0;
            key_q   <= '0;
            out_q   <= '0;
            round_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (state_q == IDLE && bus.state_in_valid) begin
                blk_q   <= bus.state_in;
                round_q <= bus.round_no;
            end
            if (state_q == REQ_KEY && bus.key_rdy) begin
                key_q <= bus.round_key;
            end
            if (state_q == XOR) begin
                out_q <= blk_q ^ key_q;
            end
            if (state_q != REQ_KEY) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_LAST) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Outputs decoded from state; everything idles at 0 and state_in_rdy is held low while in reset.
    always_comb begin
        bus.state_in_rdy    = 1'b0;
        bus.key_req         = 1'b0;
        bus.key_sel         = '0;
        bus.state_out       = '0;
        bus.state_out_valid = 1'b0;
        bus.err             = 1'b0;
        unique case (state_q)
            IDLE: bus.state_in_rdy = resetn;
            REQ_KEY: begin
                bus.key_req = 1'b1;
                bus.key_sel = round_q;
            end
            OUT: begin
                bus.state_out       = out_q;
                bus.state_out_valid = 1'b1;
            end
            ERR:     bus.err = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_aes_add_round_key.sv
// Directed bench for aes_add_round_key: FIPS-197 round 0, key delay, timeout, bad round,
// output backpressure and reset in the middle of a key request.
// Inputs driven and outputs sampled on the falling edge; DUT acts on the rising edge.
module tb_aes_add_round_key;
    import aes_pkg::*;

    logic clk;
    logic resetn;
    int   n_checks = 0;
    int   n_fail   = 0;

    aes_add_round_key_if bus();

    aes_add_round_key #(
        .NUM_ROUNDS (10),
        .KEY_TIMEOUT(16)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte n of the FIPS byte string goes to [n%4][n/4].
    function automatic aes_block_t mk_block(input logic [127:0] v);
        aes_block_t b;
        for (int n = 0; n < 16; n++) begin
            b[n % 4][n / 4] = v[127 - 8 * n -: 8];
        end
        return b;
    endfunction

    // {state_in_rdy, key_req, key_sel[3:0], state_out_valid, err}
    function automatic logic [7:0] ctl();
        return {bus.state_in_rdy, bus.key_req, bus.key_sel, bus.state_out_valid, bus.err};
    endfunction

    // Present one state for one rising edge; returns on the falling edge of cycle 1.
    task automatic send(input aes_block_t s, input logic [3:0] r);
        bus.state_in       = s;
        bus.round_no       = r;
        bus.state_in_valid = 1'b1;
        @(negedge clk);
        bus.state_in_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn             = 1'b0;
        bus.state_in       = '0;
        bus.state_in_valid = 1'b0;
        bus.round_no       = '0;
        bus.key_rdy        = 1'b0;
        bus.round_key      = '0;
        bus.state_out_rdy  = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (ctl() !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b want %b", ctl(), 8'h00);
        end
        n_checks++;
        if (bus.state_out !== '0) begin
            n_fail++;
            $display("FAIL reset_state_out: got %h want 0", bus.state_out);
        end
        resetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ctl() !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_release_rdy: got %b want %b", ctl(), {1'b1, 1'b0, 4'd0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_round0();
        aes_block_t exp_out;
        exp_out = mk_block(128'h193de3bea0f4e22b9ac68d2ae9f84808);
        send(mk_block(128'h3243f6a8885a308d313198a2e0370734), 4'd0);
        n_checks++;
        if (ctl() !== {1'b0, 1'b1, 4'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL r0_key_req: got %b want %b", ctl(), {1'b0, 1'b1, 4'd0, 1'b0, 1'b0});
        end
        bus.round_key = mk_block(128'h2b7e151628aed2a6abf7158809cf4f3c);
        bus.key_rdy   = 1'b1;
        @(negedge clk);
        bus.key_rdy   = 1'b0;
        n_checks++;
        if (ctl() !== 8'h00) begin
            n_fail++;
            $display("FAIL r0_xor_ctl: got %b want %b", ctl(), 8'h00);
        end
        @(negedge clk);
        n_checks++;
        if (ctl() !== {1'b0, 1'b0, 4'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL r0_out_ctl: got %b want %b", ctl(), {1'b0, 1'b0, 4'd0, 1'b1, 1'b0});
        end
        n_checks++;
        if (bus.state_out !== exp_out) begin
            n_fail++;
            $display("FAIL r0_state_out: got %h want %h", bus.state_out, exp_out);
        end
        @(negedge clk);
        n_checks++;
        if (ctl() !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL r0_back_idle: got %b want %b", ctl(), {1'b1, 1'b0, 4'd0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_key_delay();
        aes_block_t exp_out;
        int kr = 0;
        exp_out = mk_block(128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0);
        send(mk_block(128'h000102030405060708090a0b0c0d0e0f), 4'd3);
        n_checks++;
        if (bus.key_sel !== 4'd3) begin
            n_fail++;
            $display("FAIL delay_key_sel: got %0d want 3", bus.key_sel);
        end
        for (int i = 0; i < 5; i++) begin
            if (bus.key_req === 1'b1) kr++;
            if (i == 4) begin
                bus.round_key = mk_block({16{8'hff}});
                bus.key_rdy   = 1'b1;
            end
            @(negedge clk);
        end
        bus.key_rdy = 1'b0;
        n_checks++;
        if (kr != 5 || bus.key_req !== 1'b0) begin
            n_fail++;
            $display("FAIL delay_key_req_len: got %0d cycles (now %b) want 5 cycles (now 0)", kr, bus.key_req);
        end
        n_checks++;
        if (bus.state_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL delay_valid_early: got %b want 0", bus.state_out_valid);
        end
        @(negedge clk);
        n_checks++;
        if (bus.state_out_valid !== 1'b1 || bus.state_out !== exp_out) begin
            n_fail++;
            $display("FAIL delay_out: got valid=%b %h want valid=1 %h", bus.state_out_valid, bus.state_out, exp_out);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int kr = 0;
        int errs = 0;
        int vld = 0;
        int err_at = -1;
        bit back = 1'b0;
        send(mk_block(128'h0123456789abcdef0123456789abcdef), 4'd5);
        for (int i = 0; i < 40 && !back; i++) begin
            if (bus.key_req === 1'b1) kr++;
            if (bus.err === 1'b1) begin
                errs++;
                if (err_at < 0) err_at = i;
            end
            if (bus.state_out_valid === 1'b1) vld++;
            if (bus.state_in_rdy === 1'b1) back = 1'b1;
            else @(negedge clk);
        end
        n_checks++;
        if (kr != 16) begin
            n_fail++;
            $display("FAIL to_key_req_len: got %0d want 16", kr);
        end
        n_checks++;
        if (err_at != 16) begin
            n_fail++;
            $display("FAIL to_err_cycle: got %0d want 16", err_at);
        end
        n_checks++;
        if (errs != 1) begin
            n_fail++;
            $display("FAIL to_err_width: got %0d want 1", errs);
        end
        n_checks++;
        if (vld != 0) begin
            n_fail++;
            $display("FAIL to_no_output: got %0d valid cycles want 0", vld);
        end
        n_checks++;
        if (!back) begin
            n_fail++;
            $display("FAIL to_back_idle: got no state_in_rdy within 40 cycles want rdy");
        end
    endtask

    task automatic test_bad_round();
        send(mk_block(128'h11111111222222223333333344444444), 4'd11);
        n_checks++;
        if (ctl() !== {1'b0, 1'b0, 4'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL bad_round_err: got %b want %b", ctl(), {1'b0, 1'b0, 4'd0, 1'b0, 1'b1});
        end
        @(negedge clk);
        n_checks++;
        if (ctl() !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL bad_round_idle: got %b want %b", ctl(), {1'b1, 1'b0, 4'd0, 1'b0, 1'b0});
        end
    endtask

    task automatic test_backpressure();
        aes_block_t exp_out;
        exp_out = mk_block(128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0);
        bus.state_out_rdy = 1'b0;
        send(mk_block(128'h00112233445566778899aabbccddeeff), 4'd10);
        n_checks++;
        if (ctl() !== {1'b0, 1'b1, 4'd10, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_round10_req: got %b want %b", ctl(), {1'b0, 1'b1, 4'd10, 1'b0, 1'b0});
        end
        bus.round_key = mk_block({16{8'h0f}});
        bus.key_rdy   = 1'b1;
        @(negedge clk);
        bus.key_rdy   = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ctl() !== {1'b0, 1'b0, 4'd0, 1'b1, 1'b0} || bus.state_out !== exp_out) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got %b %h want %b %h", i, ctl(), bus.state_out,
                         {1'b0, 1'b0, 4'd0, 1'b1, 1'b0}, exp_out);
            end
            bus.state_in       = mk_block({16{8'h5a}});
            bus.round_no       = 4'd2;
            bus.state_in_valid = 1'b1;
            bus.round_key      = mk_block({16{8'ha5}});
            bus.key_rdy        = 1'b1;
            if (i == 3) bus.state_out_rdy = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (ctl() !== {1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL bp_input_ignored: got %b want %b", ctl(), {1'b1, 1'b0, 4'd0, 1'b0, 1'b0});
        end
        bus.state_in_valid = 1'b0;
        bus.key_rdy        = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        send(mk_block(128'hdeadbeefdeadbeefdeadbeefdeadbeef), 4'd4);
        n_checks++;
        if (ctl() !== {1'b0, 1'b1, 4'd4, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL rm_in_req_key: got %b want %b", ctl(), {1'b0, 1'b1, 4'd4, 1'b0, 1'b0});
        end
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if (ctl() !== 8'h00 || bus.state_out !== '0) begin
            n_fail++;
            $display("FAIL rm_async_clear: got %b %h want %b 0", ctl(), bus.state_out, 8'h00);
        end
        @(negedge clk);
        resetn        = 1'b1;
        bus.round_key = mk_block({16{8'h3c}});
        bus.key_rdy   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.state_out_valid !== 1'b0 || bus.key_req !== 1'b0 || bus.err !== 1'b0) bad++;
        end
        bus.key_rdy = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rm_no_output: got %0d active cycles want 0", bad);
        end
        n_checks++;
        if (bus.state_in_rdy !== 1'b1) begin
            n_fail++;
            $display("FAIL rm_idle_after: got %b want 1", bus.state_in_rdy);
        end
    endtask

    initial begin
        test_reset();
        test_round0();
        test_key_delay();
        test_timeout();
        test_bad_round();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded 100000 time units");
        $fatal(1);
    end

endmodule

// File: doc/aes_add_round_key.md
AES_ADD_ROUND_KEY -- requirements
Module: aes_add_round_key

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter NUM_ROUNDS, default 10, SHALL set the highest legal round index.
REQ-003 Parameter KEY_TIMEOUT, default 16, SHALL set the maximum number of cycles to wait for key_rdy.
REQ-004 clk  input  1  SHALL be the rising-edge clock.
REQ-005 resetn  input  1  SHALL be the asynchronous active-low reset.
REQ-006 state_in  input  8b x [3:0][3:0]  SHALL carry the AES state matrix, indexed [row][col].
REQ-007 state_in_valid  input  1  SHALL mark state_in and round_no as valid.
REQ-008 round_no  input  4  SHALL give the round index 0..NUM_ROUNDS.
REQ-009 state_in_rdy  output  1  SHALL signal that the block can accept a state.
REQ-010 key_req  output  1  SHALL request a round key from the key expander (drives its encrypt_en).
REQ-011 key_sel  output  4  SHALL select the requested round key.
REQ-012 key_rdy  input  1  SHALL mark round_key as valid.
REQ-013 round_key  input  8b x [3:0][3:0]  SHALL carry the round key, indexed [row][col].
REQ-014 state_out  output  8b x [3:0][3:0]  SHALL carry the result, state_in XOR round_key.
REQ-015 state_out_valid  output  1  SHALL mark state_out as valid.
REQ-016 state_out_rdy  input  1  SHALL signal that the downstream stage accepts state_out.
REQ-017 err  output  1  SHALL give a one-cycle error pulse.

Function
REQ-018 The FSM SHALL have the states IDLE, REQ_KEY, XOR, OUT and ERR.
REQ-019 In IDLE, state_in_rdy SHALL be 1 and all other outputs SHALL be 0.
REQ-020 In IDLE, when state_in_valid=1, the block SHALL register state_in and round_no and go to REQ_KEY, or to ERR if round_no > NUM_ROUNDS.
REQ-021 In REQ_KEY, the block SHALL hold key_req=1 and key_sel=the registered round_no, and SHALL count wait cycles from 0.
REQ-022 In REQ_KEY, when key_rdy=1, the block SHALL register round_key and go to XOR.
REQ-023 In REQ_KEY, if the wait count reaches KEY_TIMEOUT-1 without key_rdy, the block SHALL go to ERR.
REQ-024 If key_rdy and the timeout occur in the same cycle, key_rdy SHALL win.
REQ-025 In XOR, the block SHALL register state_out = state XOR key bytewise for all 16 bytes, then go to OUT.
REQ-026 In XOR, key_req SHALL be 0.
REQ-027 In OUT, state_out_valid SHALL be 1 and state_out SHALL be stable until state_out_rdy=1.
REQ-028 In OUT, when state_out_rdy=1, the block SHALL return to IDLE on the next cycle.
REQ-029 In ERR, err SHALL be 1 for one cycle, no output SHALL be produced, and the block SHALL then go to IDLE.
REQ-030 Latency SHALL be: input accepted at cycle 0, key_req from cycle 1, key_rdy sampled at cycle k, state_out_valid at cycle k+2.
REQ-031 state_in_valid SHALL be ignored outside IDLE, and state_in_rdy SHALL be 0 there.
REQ-032 key_rdy SHALL be ignored outside REQ_KEY.
REQ-033 The wait counter SHALL saturate and SHALL NOT wrap.
REQ-034 Round 0 SHALL be a legal key request (initial key whitening).

Reset
REQ-035 Reset assertion SHALL move the FSM to IDLE immediately, including in the middle of an operation.
REQ-036 During reset, state_out, the registered key, the registered state and the counter SHALL all be 0.
REQ-037 During reset, err, key_req, key_sel and state_out_valid SHALL be 0, and state_in_rdy SHALL be 0.
REQ-038 In the first clock after reset release, state_in_rdy SHALL be 1.
REQ-039 An operation interrupted by reset SHALL NOT produce an output.

Structure
REQ-040 The shared package aes_pkg SHALL hold the state/key byte-matrix typedef, NUM_ROUNDS_AES128=10 and the FSM state enum.
REQ-041 No sub-module SHALL be used: the XOR is inline, and the FSM and counter live in this module.

Verification
REQ-042 Directed test, round 0 per FIPS-197 App. B, input byte n at [n%4][n/4]:
- state_in = 32 43 f6 a8 88 5a 30 8d 31 31 98 a2 e0 37 07 34
- round_key = 2b 7e 15 16 28 ae d2 a6 ab f7 15 88 09 cf 4f 3c
- Required: state_out = 19 3d e3 be a0 f4 e2 2b 9a c6 8d 2a e9 f8 48 08 and key_sel=0.
REQ-043 Directed test: key_rdy delayed 5 cycles -> key_req held for 5 cycles, state_out_valid exactly 2 cycles after key_rdy.
REQ-044 Directed test: key_rdy never asserted -> err pulse 1 cycle after KEY_TIMEOUT cycles in REQ_KEY, no state_out_valid, back to IDLE.
REQ-045 Directed test: round_no=11 -> err pulse, no key_req, state_in_rdy=1 again within 2 cycles.
REQ-046 Directed test: state_out_rdy=0 for 4 cycles -> state_out stable and valid held, and a new state_in_valid is ignored until accepted.
REQ-047 Directed test: resetn low while in REQ_KEY -> all outputs 0 immediately, and no output after release.
